can_tx_frame: RTL and testbench

Transmit-side CAN 2.0A frame builder and serializer. Consumes the toggling `baud_clk` from the bit-rate divider and treats each rising edge as one nominal bit boundary. It latches a standard data frame (11-bit ID, DLC, up to 8 data bytes), computes CRC-15, inserts stuff bits, and drives `can_tx` one bit per baud period, from SOF through interframe space. Sits between the host/command logic and the CAN transceiver TX pin.

---
 rtl/can_tx_frame_if.sv | 24 ++
 rtl/can_tx_frame.sv | 239 +++++++++++++++++++++++
 tb/tb_can_tx_frame.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_frame_if.sv
// Host/bus-side signal bundle for the CAN 2.0A transmit frame builder.
// master = host/bench side, slave = can_tx_frame.
interface can_tx_frame_if;
   logic        baud_clk;
   logic        start;
   logic [10:0] id;
   logic [3:0]  dlc;
   logic [63:0] data;
   logic        can_rx;
   logic        busy;
   logic        done;
   logic        can_tx;
   logic        ack_err;

   modport master (
      output baud_clk, start, id, dlc, data, can_rx,
      input  busy, done, can_tx, ack_err
   );

   modport slave (
      input  baud_clk, start, id, dlc, data, can_rx,
      output busy, done, can_tx, ack_err
   );
endinterface

// File: rtl/can_tx_frame.sv
// CAN 2.0A data-frame builder/serializer: CRC-15, bit stuffing, one bit per baud_clk rise.
// Define CAN_ACK_CHECK_EN to sample can_rx in the ACK slot and raise a sticky ack_err.
module can_tx_frame (
   input  logic          clk,
   input  logic          rst,
   can_tx_frame_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL,
      S_ACK, S_ACK_DEL, S_EOF, S_IFS, S_END
   } state_t;

   state_t      state_reg, state_next;
   logic [6:0]  cnt_reg, cnt_next;
   logic [10:0] id_reg, id_next;
   logic [3:0]  dlc_reg, dlc_next;
   logic [6:0]  nbits_reg, nbits_next;
   logic [63:0] data_reg, data_next;
   logic [14:0] crc_reg, crc_next;
   logic        run_bit_reg, run_bit_next;
   logic [2:0]  run_len_reg, run_len_next;
   logic        baud_q;
   logic        can_tx_reg, can_tx_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        ack_err_reg, ack_err_next;

   logic        rise;
   logic        ack_fail;
   logic [3:0]  n_bytes;
   logic        bit_val;
   logic        in_stuff;
   logic        crc_en;

   assign rise    = bus.baud_clk & ~baud_q;
   assign n_bytes = (bus.dlc > 4'd8) ? 4'd8 : bus.dlc;

`ifdef CAN_ACK_CHECK_EN
   logic fall;
   assign fall     = ~bus.baud_clk & baud_q;
   // ACK_DEL is the next field, so the bus is still inside the ACK bit here
   assign ack_fail = fall && (state_reg == S_ACK_DEL) && bus.can_rx;
`else
   logic unused_can_rx;
   assign unused_can_rx = bus.can_rx;
   assign ack_fail      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= 7'd0;
         id_reg      <= 11'd0;
         dlc_reg     <= 4'd0;
         nbits_reg   <= 7'd0;
         data_reg    <= 64'd0;
         crc_reg     <= 15'd0;
         run_bit_reg <= 1'b0;
         run_len_reg <= 3'd0;
         baud_q      <= 1'b0;
         can_tx_reg  <= 1'b1;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         ack_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         id_reg      <= id_next;
         dlc_reg     <= dlc_next;
         nbits_reg   <= nbits_next;
         data_reg    <= data_next;
         crc_reg     <= crc_next;
         run_bit_reg <= run_bit_next;
         run_len_reg <= run_len_next;
         baud_q      <= bus.baud_clk;
         can_tx_reg  <= can_tx_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         ack_err_reg <= ack_err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      id_next      = id_reg;
      dlc_next     = dlc_reg;
      nbits_next   = nbits_reg;
      data_next    = data_reg;
      crc_next     = crc_reg;
      run_bit_next = run_bit_reg;
      run_len_next = run_len_reg;
      can_tx_next  = can_tx_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      ack_err_next = ack_err_reg;
      bit_val      = 1'b1;
      in_stuff     = 1'b0;
      crc_en       = 1'b0;

      if (state_reg == S_IDLE) begin
         if (bus.start) begin
            id_next      = bus.id;
            dlc_next     = bus.dlc;
            data_next    = bus.data;
            nbits_next   = {n_bytes, 3'b000};
            crc_next     = 15'd0;
            run_len_next = 3'd0;
            cnt_next     = 7'd0;
            busy_next    = 1'b1;
            ack_err_next = 1'b0;
            state_next   = S_SOF;
         end
      end else if (rise) begin
         if (run_len_reg == 3'd5) begin
            // Stuff bit: complement of the run, starts a new run, field and CRC hold
            can_tx_next  = ~run_bit_reg;
            run_bit_next = ~run_bit_reg;
            run_len_next = 3'd1;
         end else begin
            case (state_reg)
               S_SOF: begin
                  bit_val    = 1'b0;
                  in_stuff   = 1'b1;
                  crc_en     = 1'b1;
                  cnt_next   = 7'd0;
                  state_next = S_ARB;
               end
               S_ARB: begin
                  // ID shifts out MSB first; after 11 shifts the vacated zero is RTR
                  bit_val  = id_reg[10];
                  id_next  = {id_reg[9:0], 1'b0};
                  in_stuff = 1'b1;
                  crc_en   = 1'b1;
                  if (cnt_reg == 7'd11) begin
                     cnt_next   = 7'd0;
                     state_next = S_CTRL;
                  end else begin
                     cnt_next = cnt_reg + 7'd1;
                  end
               end
               S_CTRL: begin
                  in_stuff = 1'b1;
                  crc_en   = 1'b1;
                  if (cnt_reg >= 7'd2) begin
                     bit_val  = dlc_reg[3];
                     dlc_next = {dlc_reg[2:0], 1'b0};
                  end else begin
                     bit_val = 1'b0;
                  end
                  if (cnt_reg == 7'd5) begin
                     cnt_next   = 7'd0;
                     state_next = (nbits_reg == 7'd0) ? S_CRC : S_DATA;
                  end else begin
                     cnt_next = cnt_reg + 7'd1;
                  end
               end
               S_DATA: begin
                  bit_val   = data_reg[63];
                  data_next = {data_reg[62:0], 1'b0};
                  in_stuff  = 1'b1;
                  crc_en    = 1'b1;
                  if (cnt_reg == nbits_reg - 7'd1) begin
                     cnt_next   = 7'd0;
                     state_next = S_CRC;
                  end else begin
                     cnt_next = cnt_reg + 7'd1;
                  end
               end
               S_CRC: begin
                  bit_val  = crc_reg[14];
                  crc_next = {crc_reg[13:0], 1'b0};
                  in_stuff = 1'b1;
                  if (cnt_reg == 7'd14) begin
                     cnt_next   = 7'd0;
                     state_next = S_CRC_DEL;
                  end else begin
                     cnt_next = cnt_reg + 7'd1;
                  end
               end
               S_CRC_DEL: state_next = S_ACK;
               S_ACK:     state_next = S_ACK_DEL;
               S_ACK_DEL: begin
                  cnt_next   = 7'd0;
                  state_next = S_EOF;
               end
               S_EOF: begin
                  if (cnt_reg == 7'd6) begin
                     cnt_next   = 7'd0;
                     state_next = S_IFS;
                  end else begin
                     cnt_next = cnt_reg + 7'd1;
                  end
               end
               S_IFS: begin
                  if (cnt_reg == 7'd2) begin
                     cnt_next   = 7'd0;
                     state_next = S_END;
                  end else begin
                     cnt_next = cnt_reg + 7'd1;
                  end
               end
               S_END: begin
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
                  state_next = S_IDLE;
               end
               default: state_next = S_IDLE;
            endcase

            can_tx_next = bit_val;
            if (crc_en) begin
               crc_next = {crc_reg[13:0], 1'b0} ^ ((bit_val ^ crc_reg[14]) ? 15'h4599 : 15'h0000);
            end
            if (in_stuff) begin
               if ((run_len_reg != 3'd0) && (bit_val == run_bit_reg)) begin
                  run_len_next = run_len_reg + 3'd1;
               end else begin
                  run_len_next = 3'd1;
                  run_bit_next = bit_val;
               end
            end else begin
               run_len_next = 3'd0;
            end
         end
      end

      if (ack_fail) begin
         ack_err_next = 1'b1;
      end
   end

   assign bus.can_tx  = can_tx_reg;
   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.ack_err = ack_err_reg;

endmodule

// File: tb/tb_can_tx_frame.sv
// Directed bench for can_tx_frame: captures can_tx at each baud midpoint and compares
// against hand-derived patterns and a CAN 2.0A / CRC-15 reference model.
module tb_can_tx_frame;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic baud_r = 1'b0;

   can_tx_frame_if bus ();

   can_tx_frame dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.baud_clk = baud_r;

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int bdiv = 0;
   bit cap_on = 1'b1;
   bit cap[$];
   bit frame[$];
   bit model_q[$];
   bit ustream[$];

   // Baud generator (8 clk period) plus midpoint capture of can_tx while busy
   always @(negedge clk) begin
      if (bus.done) done_cnt++;
      if (bdiv == 3) begin
         bdiv = 0;
         if (baud_r && cap_on && bus.busy) cap.push_back(bus.can_tx);
         baud_r = ~baud_r;
      end else begin
         bdiv++;
      end
   end

   function automatic int sof_idx(int from);
      for (int i = from; i < cap.size(); i++)
         if (cap[i] == 1'b0) return i;
      return -1;
   endfunction

   task automatic build_frame(input int from);
      int s;
      frame = {};
      s = sof_idx(from);
      if (s >= 0)
         for (int i = s; i < cap.size(); i++) frame.push_back(cap[i]);
   endtask

   task automatic build_model(input logic [10:0] mid, input logic [3:0] mdlc, input logic [63:0] mdata);
      bit u[$];
      int n;
      int run;
      bit last;
      bit fb;
      logic [14:0] crc;
      u = {};
      u.push_back(1'b0);
      for (int i = 10; i >= 0; i--) u.push_back(mid[i]);
      u.push_back(1'b0);
      u.push_back(1'b0);
      u.push_back(1'b0);
      for (int i = 3; i >= 0; i--) u.push_back(mdlc[i]);
      n = (mdlc > 4'd8) ? 8 : int'(mdlc);
      for (int i = 0; i < 8 * n; i++) u.push_back(mdata[63 - i]);
      crc = 15'd0;
      for (int i = 0; i < u.size(); i++) begin
         fb  = u[i] ^ crc[14];
         crc = {crc[13:0], 1'b0};
         if (fb) crc = crc ^ 15'h4599;
      end
      for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
      model_q = {};
      run = 0;
      last = 1'b0;
      for (int i = 0; i < u.size(); i++) begin
         model_q.push_back(u[i]);
         if (run > 0 && u[i] == last) run++;
         else begin
            run = 1;
            last = u[i];
         end
         if (run == 5) begin
            model_q.push_back(~u[i]);
            last = ~u[i];
            run = 1;
         end
      end
      for (int i = 0; i < 13; i++) model_q.push_back(1'b1);
   endtask

   task automatic destuff(input int nbytes);
      int run;
      bit last;
      bit skip;
      int stuff_end;
      stuff_end = 34 + 8 * nbytes;
      ustream = {};
      run = 0;
      last = 1'b0;
      skip = 1'b0;
      for (int i = 0; i < frame.size(); i++) begin
         if (skip) begin
            skip = 1'b0;
            last = frame[i];
            run = 1;
         end else begin
            ustream.push_back(frame[i]);
            if (run > 0 && frame[i] == last) run++;
            else begin
               run = 1;
               last = frame[i];
            end
            if (run == 5 && ustream.size() <= stuff_end) skip = 1'b1;
         end
      end
   endtask

   function automatic int first_diff();
      int lim;
      lim = (frame.size() < model_q.size()) ? frame.size() : model_q.size();
      for (int i = 0; i < lim; i++)
         if (frame[i] != model_q[i]) return i;
      if (frame.size() != model_q.size()) return lim;
      return -1;
   endfunction

   task automatic do_start(input logic [10:0] i, input logic [3:0] d, input logic [63:0] x);
      @(negedge clk);
      bus.id    = i;
      bus.dlc   = d;
      bus.data  = x;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int base, output bit to);
      int n;
      n = 0;
      while (done_cnt == base && n < 3000) begin
         @(negedge clk);
         n++;
      end
      to = (done_cnt == base);
   endtask

   task automatic wait_bits(input int from, input int nbits, output bit to);
      int n;
      int s;
      n = 0;
      to = 1'b1;
      while (n < 3000) begin
         s = sof_idx(from);
         if (s >= 0 && (cap.size() - s) >= nbits) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      int idx;
      int base;
      int d;
      bit to;
      #23;
      checks++; if (bus.can_tx !== 1'b1) begin errors++; $display("FAIL reset_can_tx: got %b want 1", bus.can_tx); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b want 0", bus.ack_err); end
      @(negedge clk);
      rst = 1'b0;

      idx = cap.size();
      do_start(11'h000, 4'd0, 64'd0);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", bus.busy); end
      wait_bits(idx, 21, to);
      checks++; if (to) begin errors++; $display("FAIL midframe_timeout: bit 20 not reached, want within 3000 cycles"); end
      checks++; if (bus.can_tx !== 1'b0) begin errors++; $display("FAIL bit20_value: got %b want 0", bus.can_tx); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.can_tx !== 1'b1) begin errors++; $display("FAIL async_rst_can_tx: got %b want 1", bus.can_tx); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b want 0", bus.busy); end
      $display("frame id=000 dlc=0 aborted by reset at bit 20");
      @(negedge clk);
      rst = 1'b0;

      base = done_cnt;
      idx = cap.size();
      build_model(11'h0A5, 4'd2, 64'hC35A_0000_0000_0000);
      do_start(11'h0A5, 4'd2, 64'hC35A_0000_0000_0000);
      wait_done(base, to);
      checks++; if (to) begin errors++; $display("FAIL post_reset_timeout: no done, want done within 3000 cycles"); end
      build_frame(idx);
      d = first_diff();
      $display("frame id=0a5 dlc=2 bits=%0d", frame.size());
      checks++; if (d != -1) begin errors++; $display("FAIL post_reset_stream: diverges at bit %0d (len %0d), want model len %0d", d, frame.size(), model_q.size()); end
   endtask

   task automatic test_zero_frame();
      int idx;
      int base;
      bit to;
      bit exp;
      base = done_cnt;
      idx = cap.size();
      do_start(11'h000, 4'd0, 64'd0);
      wait_done(base, to);
      checks++; if (to) begin errors++; $display("FAIL zero_timeout: no done, want done within 3000 cycles"); end
      build_frame(idx);
      $display("frame id=000 dlc=0 bits=%0d", frame.size());
      checks++; if (frame.size() != 53) begin errors++; $display("FAIL zero_length: got %0d want 53", frame.size()); end
      for (int p = 0; p < 53 && p < frame.size(); p++) begin
         exp = (p >= 40) ? 1'b1 : ((p % 6) == 5);
         checks++;
         if (frame[p] !== exp) begin errors++; $display("FAIL zero_bit%0d: got %b want %b", p, frame[p], exp); end
      end
      repeat (4) @(negedge clk);
      checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt - base); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b want 0", bus.busy); end
   endtask

   task automatic test_all_ones();
      int idx;
      int base;
      int d;
      bit to;
      logic [7:0] b0;
      base = done_cnt;
      idx = cap.size();
      build_model(11'h7FF, 4'd8, 64'h0123_4567_89AB_CDEF);
      do_start(11'h7FF, 4'd8, 64'h0123_4567_89AB_CDEF);
      wait_done(base, to);
      checks++; if (to) begin errors++; $display("FAIL ones_timeout: no done, want done within 3000 cycles"); end
      build_frame(idx);
      $display("frame id=7ff dlc=8 bits=%0d", frame.size());
      checks++; if (frame.size() < 13 || frame[0] !== 1'b0 || frame[6] !== 1'b0 || frame[12] !== 1'b0) begin
         errors++; $display("FAIL ones_stuff_bits: len %0d, want SOF 0 and stuff 0 at 6 and 12", frame.size());
      end
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL ones_stream: diverges at bit %0d (len %0d), want model len %0d", d, frame.size(), model_q.size()); end
      destuff(8);
      b0 = 8'h00;
      if (ustream.size() >= 27)
         for (int i = 0; i < 8; i++) b0[7 - i] = ustream[19 + i];
      checks++; if (b0 !== 8'h01) begin errors++; $display("FAIL ones_first_byte: got %h want 01", b0); end
   endtask

   task automatic test_dlc_over_8();
      int idx;
      int base;
      int d;
      bit to;
      logic [3:0] dfield;
      base = done_cnt;
      idx = cap.size();
      build_model(11'h123, 4'd15, 64'hFEDC_BA98_7654_3210);
      do_start(11'h123, 4'd15, 64'hFEDC_BA98_7654_3210);
      wait_done(base, to);
      checks++; if (to) begin errors++; $display("FAIL dlc15_timeout: no done, want done within 3000 cycles"); end
      build_frame(idx);
      $display("frame id=123 dlc=15 bits=%0d", frame.size());
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL dlc15_stream: diverges at bit %0d (len %0d), want model len %0d", d, frame.size(), model_q.size()); end
      destuff(8);
      dfield = 4'h0;
      if (ustream.size() >= 19)
         for (int i = 0; i < 4; i++) dfield[3 - i] = ustream[15 + i];
      checks++; if (dfield !== 4'hF) begin errors++; $display("FAIL dlc15_field: got %b want 1111", dfield); end
      checks++; if (ustream.size() != 111) begin errors++; $display("FAIL dlc15_unstuffed_len: got %0d want 111", ustream.size()); end
   endtask

   task automatic test_start_ignored();
      int idx;
      int base;
      int d;
      bit to;
      base = done_cnt;
      idx = cap.size();
      build_model(11'h2B4, 4'd1, 64'h5A00_0000_0000_0000);
      do_start(11'h2B4, 4'd1, 64'h5A00_0000_0000_0000);
      wait_bits(idx, 11, to);
      checks++; if (to) begin errors++; $display("FAIL ignore_bit10_timeout: bit 10 not reached"); end
      do_start(11'h7FF, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done(base, to);
      checks++; if (to) begin errors++; $display("FAIL ignore_timeout: no done, want done within 3000 cycles"); end
      build_frame(idx);
      $display("frame id=2b4 dlc=1 bits=%0d (extra start at bit 10)", frame.size());
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL ignore_stream: diverges at bit %0d (len %0d), want model len %0d", d, frame.size(), model_q.size()); end
      repeat (400) @(negedge clk);
      checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - base); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_second_frame: busy %b want 0", bus.busy); end
   endtask

`ifdef CAN_ACK_CHECK_EN
   task automatic test_ack();
      int base;
      bit to;
      bus.can_rx = 1'b1;
      base = done_cnt;
      do_start(11'h055, 4'd1, 64'hA500_0000_0000_0000);
      wait_done(base, to);
      $display("frame id=055 dlc=1 can_rx=1 ack_err=%b", bus.ack_err);
      checks++; if (to) begin errors++; $display("FAIL ack_nack_timeout: no done"); end
      checks++; if (bus.ack_err !== 1'b1) begin errors++; $display("FAIL ack_nack_flag: got %b want 1", bus.ack_err); end

      bus.can_rx = 1'b0;
      base = done_cnt;
      do_start(11'h055, 4'd1, 64'hA500_0000_0000_0000);
      checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL ack_clear_on_start: got %b want 0", bus.ack_err); end
      wait_done(base, to);
      $display("frame id=055 dlc=1 can_rx=0 ack_err=%b", bus.ack_err);
      checks++; if (to) begin errors++; $display("FAIL ack_ok_timeout: no done"); end
      checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL ack_ok_flag: got %b want 0", bus.ack_err); end
      bus.can_rx = 1'b1;
   endtask
`else
   task automatic test_ack();
      int base;
      bit to;
      bus.can_rx = 1'b1;
      base = done_cnt;
      do_start(11'h055, 4'd1, 64'hA500_0000_0000_0000);
      wait_done(base, to);
      $display("frame id=055 dlc=1 can_rx=1 ack_err=%b", bus.ack_err);
      checks++; if (to) begin errors++; $display("FAIL ack_off_timeout: no done"); end
      checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL ack_off_flag: got %b want 0", bus.ack_err); end
   endtask
`endif

   initial begin
      bus.start  = 1'b0;
      bus.id     = 11'd0;
      bus.dlc    = 4'd0;
      bus.data   = 64'd0;
      bus.can_rx = 1'b1;
      test_reset();
      test_zero_frame();
      test_all_ones();
      test_dlc_over_8();
      test_start_ignored();
      test_ack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
